// File: rtl/ripple_carry_adder.sv
// ============================================================================
// Module      : ripple_carry_adder
// Description : WIDTH-bit ripple-carry adder built from a chain of full-adder
//               cells, with {Cout, Sum} = A + B + Cin registered (1-cycle
//               latency). Optional macro OVERFLOW_FLAG_EN adds a registered
//               two's-complement overflow output Ovf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             Ovf
`endif
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_c[0] = Cin;

    // Carry ripples strictly from bit 0 upward; no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_full_adder u_fa (
            .i_a (A[i]),
            .i_b (B[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[WIDTH];
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;

`ifdef OVERFLOW_FLAG_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end

    assign Ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
// Directed self-checking bench for ripple_carry_adder at WIDTH=8, 1 and 16.
`default_nettype none

module tb_ripple_carry_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        cin8 = 1'b0;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;

    logic [0:0]  a1 = '0, b1 = '0;
    logic        cin1 = 1'b0;
    logic [0:0]  sum1;
    logic        cout1;
    logic        ovf1;

    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0;
    logic [15:0] sum16;
    logic        cout16;
    logic        ovf16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst), .A (a8), .B (b8), .Cin (cin8),
        .Sum (sum8), .Cout (cout8)
`ifdef OVERFLOW_FLAG_EN
        , .Ovf (ovf8)
`endif
    );

    ripple_carry_adder #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst), .A (a1), .B (b1), .Cin (cin1),
        .Sum (sum1), .Cout (cout1)
`ifdef OVERFLOW_FLAG_EN
        , .Ovf (ovf1)
`endif
    );

    ripple_carry_adder #(.WIDTH(16)) u_dut16 (
        .clk (clk), .rst (rst), .A (a16), .B (b16), .Cin (cin16),
        .Sum (sum16), .Cout (cout16)
`ifdef OVERFLOW_FLAG_EN
        , .Ovf (ovf16)
`endif
    );

`ifndef OVERFLOW_FLAG_EN
    assign ovf8  = 1'b0;
    assign ovf1  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    task automatic test_reset();
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cout8, sum8} !== 9'h000 || ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got cout=%b sum=%h ovf=%b, want cout=0 sum=00 ovf=0",
                     cout8, sum8, ovf8);
        end
        total++;
        if ({cout1, sum1} !== 2'b00 || {cout16, sum16} !== 17'h0) begin
            bad++;
            $display("FAIL reset_hold_w1_w16: got w1=%b w16=%h, want 0 and 0",
                     {cout1, sum1}, {cout16, sum16});
        end
        // First edge after release captures inputs present at that edge: A5+5A+1 = 0x100.
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cout8, sum8} !== 9'h100) begin
            bad++;
            $display("FAIL reset_release: got {cout,sum}=%h, want 100", {cout8, sum8});
        end
        // Asynchronous assertion between edges.
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cout8, sum8} !== 9'h000 || ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got {cout,sum}=%h ovf=%b, want 000 ovf=0",
                     {cout8, sum8}, ovf8);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_identity();
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cout8, sum8} !== 9'h000) begin
            bad++;
            $display("FAIL zero: got {cout,sum}=%h, want 000", {cout8, sum8});
        end
        a8 = 8'h3C; b8 = 8'h00; cin8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({cout8, sum8} !== 9'h03D) begin
            bad++;
            $display("FAIL identity_cin: got {cout,sum}=%h, want 03D", {cout8, sum8});
        end
    endtask

    task automatic test_wrap();
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cout8, sum8} !== 9'h100) begin
            bad++;
            $display("FAIL wrap_ff_01: got {cout,sum}=%h, want 100", {cout8, sum8});
        end
`ifdef OVERFLOW_FLAG_EN
        total++;
        if (ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL ovf_ff_01: got ovf=%b, want 0", ovf8);
        end
`endif
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({cout8, sum8} !== 9'h1FF) begin
            bad++;
            $display("FAIL max_ff_ff_1: got {cout,sum}=%h, want 1FF", {cout8, sum8});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] va [4] = '{8'h7F, 8'h80, 8'h7F, 8'h40};
        logic [7:0] vb [4] = '{8'h01, 8'h80, 8'h00, 8'h3F};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] vr [4] = '{9'h080, 9'h100, 9'h080, 9'h07F};
        logic       vo [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            a8 = va[i]; b8 = vb[i]; cin8 = vc[i];
            @(posedge clk); #1;
            total++;
            if ({cout8, sum8} !== vr[i]) begin
                bad++;
                $display("FAIL signed_sum[%0d]: got {cout,sum}=%h, want %h",
                         i, {cout8, sum8}, vr[i]);
            end
`ifdef OVERFLOW_FLAG_EN
            total++;
            if (ovf8 !== vo[i]) begin
                bad++;
                $display("FAIL ovf[%0d]: got ovf=%b, want %b", i, ovf8, vo[i]);
            end
`else
            if (vo[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [8] = '{8'h24, 8'h09, 8'h0D, 8'h65, 8'h01, 8'h76, 8'hED, 8'hF9};
        logic [7:0] vb [8] = '{8'h81, 8'h63, 8'h8D, 8'h12, 8'h0D, 8'h3D, 8'h8C, 8'hC6};
        logic       vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0] vr [8] = '{9'h0A5, 9'h06C, 9'h09B, 9'h077, 9'h00F, 9'h0B3, 9'h17A, 9'h1BF};
        for (int i = 0; i < 8; i++) begin
            a8 = va[i]; b8 = vb[i]; cin8 = vc[i];
            @(posedge clk); #1;
            total++;
            if ({cout8, sum8} !== vr[i]) begin
                bad++;
                $display("FAIL b2b_w8[%0d]: got {cout,sum}=%h, want %h",
                         i, {cout8, sum8}, vr[i]);
            end
        end
    endtask

    task automatic test_width1();
        // Rows are {a, b, cin} -> {cout, sum}.
        logic [2:0] vin [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [1:0] vr  [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            a1 = vin[i][2]; b1 = vin[i][1]; cin1 = vin[i][0];
            @(posedge clk); #1;
            total++;
            if ({cout1, sum1} !== vr[i]) begin
                bad++;
                $display("FAIL b2b_w1[%0d]: got {cout,sum}=%b, want %b",
                         i, {cout1, sum1}, vr[i]);
            end
        end
    endtask

    task automatic test_width16();
        logic [15:0] va [6] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'h8000, 16'h7FFF, 16'h00FF};
        logic [15:0] vb [6] = '{16'h0001, 16'hFFFF, 16'h5678, 16'h8000, 16'h0001, 16'h0001};
        logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [16:0] vr [6] = '{17'h10000, 17'h1FFFF, 17'h068AC, 17'h10001, 17'h08000, 17'h00100};
        for (int i = 0; i < 6; i++) begin
            a16 = va[i]; b16 = vb[i]; cin16 = vc[i];
            @(posedge clk); #1;
            total++;
            if ({cout16, sum16} !== vr[i]) begin
                bad++;
                $display("FAIL b2b_w16[%0d]: got {cout,sum}=%h, want %h",
                         i, {cout16, sum16}, vr[i]);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_zero_identity();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_width1();
        test_width16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
